io_stream_port: RTL and testbench

- Responder on the external IO bus driven by the core's IO unit (8-bit address, native-width data, single-cycle read/write strobes).
- Decodes a 4-address window at BASE_ADDR.
- Bridges core IO accesses to two streaming FIFOs:
  - TX FIFO: core writes → valid/ready output stream.
  - RX FIFO: valid/ready input stream → core reads.
- Sits in the top-level next to the core and feeds off-chip or accelerator stream logic.

---
 rtl/io_stream_port.sv | 133 +++++++++++++
 tb/tb_io_stream_port.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_stream_port.sv
// IO-bus responder bridging a 4-register window to a TX and an RX valid/ready stream.
// The TX FIFO is filled by core writes and the RX FIFO is drained by core reads.
module io_stream_port #(
    parameter int         nat_w     = 16,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] BASE_ADDR = 8'h40
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [7:0]       io_addr_i,
    input  logic [nat_w-1:0] io_data_i,
    input  logic             io_wr_strobe_i,
    input  logic             io_rd_strobe_i,
    output logic [nat_w-1:0] io_data_o,
    output logic [nat_w-1:0] tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    input  logic [nat_w-1:0] rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [nat_w-1:0] tx_mem [DEPTH];
    logic [nat_w-1:0] rx_mem [DEPTH];

    logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CNT_W-1:0] tx_count, rx_count;
    logic             tx_overflow, rx_underflow;

    logic       hit;
    logic [1:0] off;
    logic       wr_data, rd_data, wr_ctrl, flush, clr_sticky;
    logic       tx_empty, tx_full, rx_nonempty, rx_full;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic       set_overflow, set_underflow;
    logic [nat_w-1:0] rx_head, status;

    assign hit        = (io_addr_i[7:2] == BASE_ADDR[7:2]);
    assign off        = io_addr_i[1:0];
    assign wr_data    = io_wr_strobe_i && hit && (off == 2'd0);
    assign rd_data    = io_rd_strobe_i && hit && (off == 2'd0);
    assign wr_ctrl    = io_wr_strobe_i && hit && (off == 2'd2);
    assign flush      = wr_ctrl && io_data_i[0];
    assign clr_sticky = wr_ctrl && io_data_i[1];

    assign tx_empty    = (tx_count == '0);
    assign tx_full     = (tx_count == FULL_CNT);
    assign rx_nonempty = (rx_count != '0);
    assign rx_full     = (rx_count == FULL_CNT);

    // Fullness/emptiness is judged on pre-edge counts, so a write into a full
    // TX FIFO is dropped even when the stream drains an entry in the same cycle.
    assign tx_push       = wr_data && !tx_full;
    assign tx_pop        = !tx_empty && tx_ready_i;
    assign rx_push       = rx_valid_i && !rx_full;
    assign rx_pop        = rd_data && rx_nonempty;
    assign set_overflow  = wr_data && tx_full;
    assign set_underflow = rd_data && !rx_nonempty;

    assign tx_valid_o = !tx_empty;
    assign tx_data_o  = tx_empty ? '0 : tx_mem[tx_rd_ptr];
    assign rx_ready_o = !rx_full;
    assign rx_head    = rx_nonempty ? rx_mem[rx_rd_ptr] : '0;

    always_comb begin
        status        = '0;
        status[0]     = rx_nonempty;
        status[1]     = rx_full;
        status[2]     = tx_empty;
        status[3]     = tx_full;
        status[4]     = tx_overflow;
        status[5]     = rx_underflow;
        status[15:8]  = 8'(rx_count);
    end

    // Zero unless this window is read, so responders can be OR-merged.
    always_comb begin
        io_data_o = '0;
        if (io_rd_strobe_i && hit) begin
            case (off)
                2'd0:    io_data_o = rx_head;
                2'd1:    io_data_o = status;
                2'd2:    io_data_o[7:0] = 8'(tx_count);
                default: io_data_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            tx_count     <= '0;
            rx_count     <= '0;
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
        end else begin
            if (flush) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
                tx_count  <= '0;
                rx_count  <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
                tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
                rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
            end
            // Setting a sticky flag wins over clearing it in the same cycle.
            if (set_overflow)    tx_overflow <= 1'b1;
            else if (clr_sticky) tx_overflow <= 1'b0;
            if (set_underflow)   rx_underflow <= 1'b1;
            else if (clr_sticky) rx_underflow <= 1'b0;
        end
    end

    // Storage is data only; validity is tracked entirely by the counts.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= io_data_i;
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data_i;
    end

endmodule

// File: tb/tb_io_stream_port.sv
// Bench for io_stream_port: hand vectors, corner sequences and randomized traffic
// checked against a queue-based model of the register window and FIFOs.
module tb_io_stream_port;

    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [7:0]  io_addr_i;
    logic [15:0] io_data_i;
    logic        io_wr_strobe_i, io_rd_strobe_i;
    logic [15:0] io_data_o, tx_data_o, rx_data_i;
    logic        tx_valid_o, tx_ready_i, rx_valid_i, rx_ready_o;

    io_stream_port #(.nat_w(16), .DEPTH(DEPTH), .BASE_ADDR(8'h40)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .io_addr_i(io_addr_i), .io_data_i(io_data_i),
        .io_wr_strobe_i(io_wr_strobe_i), .io_rd_strobe_i(io_rd_strobe_i),
        .io_data_o(io_data_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    logic        m_of = 1'b0, m_uf = 1'b0;

    logic [15:0] last_io, last_txd;
    logic        last_txv, last_rxr;

    typedef struct {
        logic        wr, rd;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        txr, rxv;
        logic [15:0] rxd;
        logic [15:0] e_io;
        logic        e_txv;
        logic [15:0] e_txd;
        logic        e_rxr;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic rd, input logic [7:0] addr);
        logic [15:0] s;
        s = '0;
        if (!rd || addr[7:2] != 6'h10) return 16'h0;
        case (addr[1:0])
            2'd0: return (rx_q.size() != 0) ? rx_q[0] : 16'h0;
            2'd1: begin
                s[0]    = rx_q.size() != 0;
                s[1]    = rx_q.size() == DEPTH;
                s[2]    = tx_q.size() == 0;
                s[3]    = tx_q.size() == DEPTH;
                s[4]    = m_of;
                s[5]    = m_uf;
                s[15:8] = 8'(rx_q.size());
                return s;
            end
            2'd2: return 16'(tx_q.size());
            default: return 16'h0;
        endcase
    endfunction

    // One bus cycle: drive, sample mid-cycle against the model, then advance model and clock.
    task automatic step(input logic wr, input logic rd, input logic [7:0] addr,
                        input logic [15:0] data, input logic txr, input logic rxv,
                        input logic [15:0] rxd);
        int  tn, rn;
        logic hit, wd, rdd, wc, s_of, s_uf;
        io_wr_strobe_i = wr; io_rd_strobe_i = rd; io_addr_i = addr; io_data_i = data;
        tx_ready_i = txr; rx_valid_i = rxv; rx_data_i = rxd;
        #4;
        last_io = io_data_o; last_txv = tx_valid_o; last_txd = tx_data_o; last_rxr = rx_ready_o;
        chk("io_data",  last_io,  model_read(rd, addr));
        chk("tx_valid", 16'(last_txv), 16'(tx_q.size() != 0));
        chk("tx_data",  last_txd, (tx_q.size() != 0) ? tx_q[0] : 16'h0);
        chk("rx_ready", 16'(last_rxr), 16'(rx_q.size() < DEPTH));
        tn  = tx_q.size();
        rn  = rx_q.size();
        hit = addr[7:2] == 6'h10;
        wd  = wr && hit && addr[1:0] == 2'd0;
        rdd = rd && hit && addr[1:0] == 2'd0;
        wc  = wr && hit && addr[1:0] == 2'd2;
        s_of = wd && tn == DEPTH;
        s_uf = rdd && rn == 0;
        if (wc && data[0]) begin
            tx_q.delete();
            rx_q.delete();
        end else begin
            if (txr && tn > 0)      void'(tx_q.pop_front());
            if (wd && tn < DEPTH)   tx_q.push_back(data);
            if (rdd && rn > 0)      void'(rx_q.pop_front());
            if (rxv && rn < DEPTH)  rx_q.push_back(rxd);
        end
        if (s_of) m_of = 1'b1; else if (wc && data[1]) m_of = 1'b0;
        if (s_uf) m_uf = 1'b1; else if (wc && data[1]) m_uf = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic txr);
        step(1'b0, 1'b0, 8'h00, 16'h0, txr, 1'b0, 16'h0);
    endtask

    initial begin
        reset_i = 1'b1;
        io_addr_i = '0; io_data_i = '0; io_wr_strobe_i = 0; io_rd_strobe_i = 0;
        tx_ready_i = 0; rx_valid_i = 0; rx_data_i = '0;

        //                wr rd addr   data      txr rxv rxd      e_io      txv e_txd     rxr
        tbl[0]  = '{1'b0,1'b1,8'h41,16'h0000,1'b0,1'b0,16'h0000,16'h0004,1'b0,16'h0000,1'b1};
        tbl[1]  = '{1'b1,1'b0,8'h40,16'hA5A5,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b1};
        tbl[2]  = '{1'b1,1'b0,8'h40,16'h1234,1'b0,1'b0,16'h0000,16'h0000,1'b1,16'hA5A5,1'b1};
        tbl[3]  = '{1'b0,1'b1,8'h42,16'h0000,1'b0,1'b0,16'h0000,16'h0002,1'b1,16'hA5A5,1'b1};
        tbl[4]  = '{1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,16'h0000,16'h0000,1'b1,16'hA5A5,1'b1};
        tbl[5]  = '{1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,16'h0000,16'h0000,1'b1,16'h1234,1'b1};
        tbl[6]  = '{1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b1};
        tbl[7]  = '{1'b0,1'b1,8'h41,16'h0000,1'b0,1'b0,16'h0000,16'h0004,1'b0,16'h0000,1'b1};
        tbl[8]  = '{1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'h0001,16'h0000,1'b0,16'h0000,1'b1};
        tbl[9]  = '{1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'h0002,16'h0000,1'b0,16'h0000,1'b1};
        tbl[10] = '{1'b0,1'b1,8'h41,16'h0000,1'b0,1'b0,16'h0000,16'h0205,1'b0,16'h0000,1'b1};
        tbl[11] = '{1'b0,1'b1,8'h40,16'h0000,1'b0,1'b0,16'h0000,16'h0001,1'b0,16'h0000,1'b1};
        tbl[12] = '{1'b0,1'b1,8'h40,16'h0000,1'b0,1'b0,16'h0000,16'h0002,1'b0,16'h0000,1'b1};
        tbl[13] = '{1'b0,1'b1,8'h40,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b1};
        tbl[14] = '{1'b0,1'b1,8'h41,16'h0000,1'b0,1'b0,16'h0000,16'h0024,1'b0,16'h0000,1'b1};
        tbl[15] = '{1'b1,1'b0,8'h42,16'h0002,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b1};
        tbl[16] = '{1'b0,1'b1,8'h41,16'h0000,1'b0,1'b0,16'h0000,16'h0004,1'b0,16'h0000,1'b1};
        tbl[17] = '{1'b0,1'b1,8'h43,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b1};
        tbl[18] = '{1'b0,1'b1,8'h44,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b1};
        tbl[19] = '{1'b1,1'b0,8'h80,16'h5555,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b1};

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_tx_valid", 16'(tx_valid_o), 16'h0);
        chk("reset_tx_data",  tx_data_o, 16'h0);
        chk("reset_rx_ready", 16'(rx_ready_o), 16'h1);
        chk("reset_io_data",  io_data_o, 16'h0);
        reset_i = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].txr, tbl[i].rxv, tbl[i].rxd);
            chk($sformatf("vec%0d_io", i),  last_io,  tbl[i].e_io);
            chk($sformatf("vec%0d_txv", i), 16'(last_txv), 16'(tbl[i].e_txv));
            chk($sformatf("vec%0d_txd", i), last_txd, tbl[i].e_txd);
            chk($sformatf("vec%0d_rxr", i), 16'(last_rxr), 16'(tbl[i].e_rxr));
        end

        // TX overflow and sticky clear
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'h40, 16'h3000 + 16'(i), 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 8'h42, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("ovf_tx_count", last_io, 16'h0008);
        step(1'b0, 1'b1, 8'h41, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("ovf_status", last_io, 16'h0018);
        step(1'b1, 1'b0, 8'h42, 16'h0002, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 8'h41, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("ovf_cleared", last_io, 16'h0008);
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            chk("ovf_drain", last_txd, 16'h3000 + 16'(i));
        end
        idle(1'b0);
        chk("ovf_drained", 16'(last_txv), 16'h0);

        // RX fill, drain in order, underflow
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b1, 16'(i));
        idle(1'b0);
        chk("rx_full_ready", 16'(last_rxr), 16'h0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 8'h40, 16'h0, 1'b0, 1'b0, 16'h0);
            chk("rx_read", last_io, 16'(i));
            chk("rx_ready_after_pop", 16'(last_rxr), 16'(i != 1));
        end
        step(1'b0, 1'b1, 8'h40, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("rx_empty_read", last_io, 16'h0);
        step(1'b0, 1'b1, 8'h41, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("rx_underflow", last_io, 16'h0024);
        step(1'b1, 1'b0, 8'h42, 16'h0002, 1'b0, 1'b0, 16'h0);

        // Concurrent pop/push and flush with a concurrent beat
        step(1'b1, 1'b0, 8'h40, 16'hBEEF, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 8'h40, 16'hCAFE, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b1, 16'h0010 + 16'(i));
        step(1'b0, 1'b1, 8'h40, 16'h0, 1'b0, 1'b1, 16'h0014);
        chk("conc_oldest", last_io, 16'h0010);
        step(1'b0, 1'b1, 8'h41, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("conc_rx_count", last_io >> 8, 16'h0004);
        step(1'b1, 1'b0, 8'h42, 16'h0001, 1'b0, 1'b1, 16'h0099);
        step(1'b0, 1'b1, 8'h41, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("flush_status", last_io, 16'h0004);
        step(1'b0, 1'b1, 8'h42, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("flush_tx_count", last_io, 16'h0000);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h40, 16'h7000 + 16'(i), 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b1, 16'h0700 + 16'(i));
        io_wr_strobe_i = 0; io_rd_strobe_i = 0; tx_ready_i = 0; rx_valid_i = 1; rx_data_i = 16'h0777;
        #2;
        chk("pre_areset_txv", 16'(tx_valid_o), 16'h1);
        reset_i = 1'b1;
        #1;
        chk("areset_txv", 16'(tx_valid_o), 16'h0);
        chk("areset_txd", tx_data_o, 16'h0);
        chk("areset_rxr", 16'(rx_ready_o), 16'h1);
        #1;
        reset_i = 1'b0;
        rx_valid_i = 0;
        tx_q.delete(); rx_q.delete(); m_of = 1'b0; m_uf = 1'b0;
        @(posedge clk_i);
        #1;
        step(1'b0, 1'b1, 8'h41, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("post_areset_status", last_io, 16'h0004);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [7:0]  a;
            logic [15:0] d;
            a = ($urandom_range(0, 9) < 8) ? {6'h10, 2'($urandom_range(0, 3))} : 8'($urandom);
            d = 16'($urandom);
            if (a == 8'h42 && $urandom_range(0, 7) != 0) d = d & 16'hFFFE;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, a, d,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
